// File: rtl/step_ctrl_pkg.sv
// step_ctrl_pkg: shared types and constants for the step controller.
//   mode_t  - operating mode from the front-panel switches
//   state_t - controller state, also shown on the HEX display
//   RUN_DIV_DEFAULT - slow-run period in clock cycles (2 Hz at 50 MHz)
package step_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_STEP     = 2'b00,
        MODE_RUN_SLOW = 2'b01,
        MODE_RUN_FAST = 2'b10,
        MODE_BURST    = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_BURST  = 2'b10,
        ST_HALTED = 2'b11
    } state_t;

    localparam int unsigned RUN_DIV_DEFAULT = 25_000_000;

endpackage

// File: rtl/step_controller_rate_divider.sv
// rate_divider: free-running modulo-RUN_DIV counter for slow-run mode.
//   clk, rst_n : clock, async active-low reset
//   clear      : synchronous clear to 0 (dominates run)
//   run        : advance the counter this cycle
//   tick       : high for the one cycle the counter sits at RUN_DIV-1 while running
module rate_divider
    import step_ctrl_pkg::*;
#(
    parameter int unsigned RUN_DIV = RUN_DIV_DEFAULT,
    parameter int unsigned DIV_W   = 25
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam logic [DIV_W-1:0] LAST = DIV_W'(RUN_DIV - 1);

    logic [DIV_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    assign tick = run && !clear && (count == LAST);

endmodule

// File: rtl/step_controller.sv
// step_controller: turns debounced key strobes into a registered one-cycle
// clock-enable for the processor. Modes: single step, slow run, fast run,
// fixed-length burst. Halt has priority over Strobe, which has priority over
// divider/burst activity.
// Optional feature: define STEP_CTRL_BREAKPOINT_EN to add a PC breakpoint
// (ports PcIn, BreakAddr, BreakArm) that stops RUN/BURST before the enable.
// Ports:
//   Clock, ResetN   : clock, async active-low reset
//   Strobe          : one-cycle key press pulse
//   Mode            : 00 STEP, 01 RUN_SLOW, 10 RUN_FAST, 11 BURST
//   BurstCount      : burst length, sampled on the starting Strobe
//   Halt            : processor halted (level)
//   Enable          : registered one-cycle processor clock-enable
//   Busy            : high in RUN or BURST
//   State           : 00 IDLE, 01 RUN, 10 BURST, 11 HALTED
//   StepCount       : wrapping count of Enable pulses
module step_controller
    import step_ctrl_pkg::*;
#(
    parameter int unsigned RUN_DIV = RUN_DIV_DEFAULT,
    parameter int unsigned DIV_W   = 25,
    parameter int unsigned BURST_W = 8
) (
    input  logic               Clock,
    input  logic               ResetN,
    input  logic               Strobe,
    input  logic [1:0]         Mode,
    input  logic [BURST_W-1:0] BurstCount,
    input  logic               Halt,
`ifdef STEP_CTRL_BREAKPOINT_EN
    input  logic [7:0]         PcIn,
    input  logic [7:0]         BreakAddr,
    input  logic               BreakArm,
`endif
    output logic               Enable,
    output logic               Busy,
    output logic [1:0]         State,
    output logic [15:0]        StepCount
);

    mode_t              mode;
    state_t             state_q, state_d;
    logic [BURST_W-1:0] remaining_q, remaining_d;
    logic               en_d;
    logic               want;      // RUN/BURST would issue an enable this cycle
    logic               bp_hit;
    logic               div_clear, div_tick;

    assign mode  = mode_t'(Mode);
    assign State = state_q;

`ifdef STEP_CTRL_BREAKPOINT_EN
    assign bp_hit = BreakArm && (PcIn == BreakAddr);
`else
    assign bp_hit = 1'b0;
`endif

    // Divider only advances while slow-running; any other cycle holds it at 0,
    // which gives both the clear-on-entry and the clear on a slow/fast switch.
    assign div_clear = !(state_q == ST_RUN && mode == MODE_RUN_SLOW);

    rate_divider #(
        .RUN_DIV (RUN_DIV),
        .DIV_W   (DIV_W)
    ) u_div (
        .clk   (Clock),
        .rst_n (ResetN),
        .clear (div_clear),
        .run   (!div_clear),
        .tick  (div_tick)
    );

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        en_d        = 1'b0;
        want        = 1'b0;
        if (Halt) begin
            state_d = ST_HALTED;
        end else begin
            case (state_q)
                ST_HALTED: begin
                    if (Strobe) state_d = ST_IDLE;
                end
                ST_IDLE: begin
                    if (Strobe) begin
                        case (mode)
                            MODE_STEP:     en_d = 1'b1;
                            MODE_RUN_SLOW,
                            MODE_RUN_FAST: state_d = ST_RUN;
                            MODE_BURST: begin
                                if (BurstCount != '0) begin
                                    state_d     = ST_BURST;
                                    remaining_d = BurstCount;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_RUN: begin
                    if (Strobe || mode == MODE_STEP || mode == MODE_BURST)
                        state_d = ST_IDLE;
                    else if (mode == MODE_RUN_FAST)
                        want = 1'b1;
                    else
                        want = div_tick;
                end
                ST_BURST: begin
                    if (Strobe || remaining_q == '0) begin
                        state_d     = ST_IDLE;
                        remaining_d = '0;
                    end else begin
                        want        = 1'b1;
                        remaining_d = remaining_q - 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            // Breakpoint swallows the enable it would have issued and parks in
            // IDLE so the next STEP strobe executes the breakpoint instruction.
            if (want && bp_hit) begin
                want        = 1'b0;
                state_d     = ST_IDLE;
                remaining_d = '0;
            end
            en_d = en_d | want;
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            Enable      <= 1'b0;
            Busy        <= 1'b0;
            StepCount   <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            Enable      <= en_d;
            Busy        <= (state_d == ST_RUN) || (state_d == ST_BURST);
            StepCount   <= StepCount + {15'd0, en_d};
        end
    end

endmodule

// File: tb/tb_step_controller.sv
// tb_step_controller: directed bench for step_controller with RUN_DIV=4.
// A cycle-level reference model tracks expected outputs and is compared on
// every falling edge; literal expectations pin key points of the sequence.
module tb_step_controller;

    localparam int RUN_DIV = 4;

    logic        Clock = 1'b0;
    logic        ResetN = 1'b0;
    logic        Strobe = 1'b0;
    logic [1:0]  Mode = 2'b00;
    logic [7:0]  BurstCount = 8'd0;
    logic        Halt = 1'b0;
    logic        Enable, Busy;
    logic [1:0]  State;
    logic [15:0] StepCount;
`ifdef STEP_CTRL_BREAKPOINT_EN
    logic [7:0]  PcIn = 8'd0;
    logic [7:0]  BreakAddr = 8'd0;
    logic        BreakArm = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    step_controller #(.RUN_DIV(RUN_DIV), .DIV_W(3), .BURST_W(8)) dut (
        .Clock      (Clock),
        .ResetN     (ResetN),
        .Strobe     (Strobe),
        .Mode       (Mode),
        .BurstCount (BurstCount),
        .Halt       (Halt),
`ifdef STEP_CTRL_BREAKPOINT_EN
        .PcIn       (PcIn),
        .BreakAddr  (BreakAddr),
        .BreakArm   (BreakArm),
`endif
        .Enable     (Enable),
        .Busy       (Busy),
        .State      (State),
        .StepCount  (StepCount)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: state 0 IDLE, 1 RUN, 2 BURST, 3 HALTED.
    logic [1:0]  m_st  = 2'd0;
    logic        m_en  = 1'b0;
    logic [15:0] m_cnt = 16'd0;
    int          m_left = 0;   // burst enables still owed
    int          m_age  = 0;   // slow-run cycles since entering RUN or leaving fast mode

    always @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            m_st <= 2'd0; m_en <= 1'b0; m_cnt <= 16'd0; m_left <= 0; m_age <= 0;
        end else begin : model
            logic [1:0] st;
            int left, age;
            logic en, want;
            st = m_st; left = m_left; age = m_age; en = 1'b0; want = 1'b0;
            if (Halt) st = 2'd3;
            else begin
                case (m_st)
                    2'd3: if (Strobe) st = 2'd0;
                    2'd0: if (Strobe) begin
                        if (Mode == 2'd0) en = 1'b1;
                        else if (Mode == 2'd3) begin
                            if (BurstCount != 8'd0) begin st = 2'd2; left = int'(BurstCount); end
                        end else begin st = 2'd1; age = 0; end
                    end
                    2'd1: begin
                        if (Strobe || Mode == 2'd0 || Mode == 2'd3) st = 2'd0;
                        else if (Mode == 2'd2) begin want = 1'b1; age = 0; end
                        else begin age = age + 1; want = (age % RUN_DIV == 0); end
                    end
                    default: begin
                        if (Strobe || left == 0) begin st = 2'd0; left = 0; end
                        else begin want = 1'b1; left = left - 1; end
                    end
                endcase
`ifdef STEP_CTRL_BREAKPOINT_EN
                if (want && BreakArm && PcIn == BreakAddr) begin
                    want = 1'b0; st = 2'd0; left = 0;
                end
`endif
                en = en | want;
            end
            m_st <= st; m_left <= left; m_age <= age; m_en <= en;
            m_cnt <= m_cnt + {15'd0, en};
        end
    end

    always @(negedge Clock) begin
        check("enable", {31'd0, Enable}, {31'd0, m_en});
        check("state", {30'd0, State}, {30'd0, m_st});
        check("busy", {31'd0, Busy}, {31'd0, (m_st == 2'd1 || m_st == 2'd2)});
        check("step_count", {16'd0, StepCount}, {16'd0, m_cnt});
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic press();
        Strobe = 1'b1;
        tick(1);
        Strobe = 1'b0;
    endtask

    initial begin
        int n, g;
        tick(2);
        check("rst_enable", {31'd0, Enable}, 32'd0);
        check("rst_state", {30'd0, State}, 32'd0);
        check("rst_count", {16'd0, StepCount}, 32'd0);
        ResetN = 1'b1;
        tick(2);

        // Single step: enable exactly one cycle after each press.
        Mode = 2'd0;
        repeat (3) begin
            press();
            check("step_en", {31'd0, Enable}, 32'd1);
            tick(1);
            check("step_gap", {31'd0, Enable}, 32'd0);
        end
        check("step_cnt", {16'd0, StepCount}, 32'd3);
        check("step_state", {30'd0, State}, 32'd0);

        // Slow run: enables at cycles 4, 8, 12, 16, 20 after entry.
        Mode = 2'd1;
        press();
        check("slow_entry", {30'd0, State}, 32'd1);
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            check("slow_en", {31'd0, Enable}, {31'd0, (k % 4 == 0)});
        end
        press();
        check("slow_exit_state", {30'd0, State}, 32'd0);
        check("slow_exit_en", {31'd0, Enable}, 32'd0);
        tick(5);
        check("slow_cnt", {16'd0, StepCount}, 32'd8);

        // Burst of 5, count latched at start, mode change ignored mid-burst.
        Mode = 2'd3; BurstCount = 8'd5;
        press();
        BurstCount = 8'd9;
        n = 0;
        for (int k = 1; k <= 8; k++) begin
            if (k == 2) Mode = 2'd0;
            tick(1);
            n += int'(Enable);
            if (k <= 5) check("burst_consec", {31'd0, Enable}, 32'd1);
        end
        check("burst_n", n, 32'd5);
        check("burst_done", {30'd0, State}, 32'd0);
        check("burst_cnt", {16'd0, StepCount}, 32'd13);
        Mode = 2'd3; BurstCount = 8'd0;
        press();
        check("burst0_state", {30'd0, State}, 32'd0);
        tick(1);
        check("burst0_en", {31'd0, Enable}, 32'd0);

        // Burst aborted by a strobe.
        BurstCount = 8'd10;
        press();
        tick(3);
        press();
        check("abort_state", {30'd0, State}, 32'd0);
        check("abort_en", {31'd0, Enable}, 32'd0);
        tick(2);

        // Fast run, switch to slow, then leave via mode change.
        Mode = 2'd2;
        press();
        tick(3);
        Mode = 2'd1;
        tick(6);
        Mode = 2'd0;
        tick(2);
        check("mode_exit", {30'd0, State}, 32'd0);

        // Halt during fast run.
        Mode = 2'd2;
        press();
        tick(3);
        Halt = 1'b1;
        tick(1);
        check("halt_en", {31'd0, Enable}, 32'd0);
        check("halt_state", {30'd0, State}, 32'd3);
        press();
        check("halt_strobe", {30'd0, State}, 32'd3);
        Halt = 1'b0;
        tick(1);
        press();
        check("unhalt_state", {30'd0, State}, 32'd0);
        check("unhalt_en", {31'd0, Enable}, 32'd0);
        // Halt beats a simultaneous step strobe.
        Mode = 2'd0; Halt = 1'b1;
        press();
        Halt = 1'b0;
        check("halt_step_en", {31'd0, Enable}, 32'd0);
        press();
        tick(1);

        // Run the counter up to FFFF, then one step wraps it.
        Mode = 2'd2;
        press();
        g = 0;
        while (m_cnt != 16'hFFFF && g < 70000) begin
            tick(1);
            g++;
        end
        check("wrap_bound", {31'd0, (g < 70000)}, 32'd1);
        press();
        check("wrap_pre", {16'd0, StepCount}, 32'hFFFF);
        Mode = 2'd0;
        press();
        check("wrap_post", {16'd0, StepCount}, 32'h0);
        check("wrap_en", {31'd0, Enable}, 32'd1);
        tick(1);

        // Asynchronous reset mid-burst.
        Mode = 2'd3; BurstCount = 8'd200;
        press();
        tick(4);
        #2 ResetN = 1'b0;
        #1;
        check("arst_enable", {31'd0, Enable}, 32'd0);
        check("arst_busy", {31'd0, Busy}, 32'd0);
        check("arst_state", {30'd0, State}, 32'd0);
        check("arst_count", {16'd0, StepCount}, 32'd0);
        tick(2);
        ResetN = 1'b1;
        tick(3);
        check("arst_after", {30'd0, State}, 32'd0);

`ifdef STEP_CTRL_BREAKPOINT_EN
        BreakAddr = 8'h10; BreakArm = 1'b1; PcIn = 8'h00;
        Mode = 2'd2;
        press();
        tick(2);
        PcIn = 8'h10;
        tick(1);
        check("bp_en", {31'd0, Enable}, 32'd0);
        check("bp_state", {30'd0, State}, 32'd0);
        Mode = 2'd0;
        press();
        check("bp_step", {31'd0, Enable}, 32'd1);
        BreakArm = 1'b0;
        tick(2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
